cfg_rd_arbiter: RTL and testbench
=================================

// Module: cfg_rd_arbiter
// PURPOSE
//  Shares the PCIe core's single configuration-space read port between NUM_REQ requesters.
//  Requesters include the BAR/config parser, a debug register reader and link-status polling.
//  Picks one requester round-robin, sequences the rd_en / rd_wr_done handshake, returns the DWORD.
//  Bounds every access with a timeout. Sits between the requesters and the core CFG port.
// PARAMETERS
//  NUM_REQ   2    number of requesters (1..8)
//  TIMEOUT   255  cycles o_cfg_rd_en may stay high without i_cfg_rd_wr_done before abort (1..65535)
// PORTS
//  clk               in   1            core user clock; the only clock
//  rst_n             in   1            reset, asynchronous assert, active-low
//  i_req             in   NUM_REQ      per-requester read request, level
//  i_req_dwaddr      in   NUM_REQ*10   per-requester DWORD address; slice k = [10k+9:10k]
//  o_gnt             out  NUM_REQ      one-hot; marks the requester owning the current access
//  o_ack             out  NUM_REQ      one-hot, one-cycle pulse; access complete
//  o_data            out  32           read data; valid in the o_ack cycle, held until the next ack
//  o_timeout         out  1            qualifies o_ack; the access aborted
//  o_busy            out  1            an access is in flight (state != IDLE)
//  o_cfg_dwaddr      out  10           to core cfg_dwaddr
//  o_cfg_rd_en       out  1            to core cfg_rd_en
//  i_cfg_do          in   32           from core cfg_do
//  i_cfg_rd_wr_done  in   1            from core cfg_rd_wr_done
// BEHAVIOUR
//  Reset values (async, immediate)
//   - o_gnt=0, o_ack=0, o_data=0, o_timeout=0, o_busy=0, o_cfg_dwaddr=0, o_cfg_rd_en=0.
//   - State IDLE, round-robin pointer at requester 0, timeout counter 0.
//  Requester rules
//   - Hold i_req and the address slice stable from assertion until its o_ack.
//   - Dropping i_req early does not cancel the access; it completes and o_ack still pulses.
//   - i_req still high in the cycle after o_ack counts as a new request.
//  Arbitration
//   - Only in IDLE. Winner = first requester with i_req=1, scanning upward from pointer.
//   - Scan wraps at NUM_REQ-1 -> 0. Pointer becomes winner+1 (mod NUM_REQ) on grant.
//   - Simultaneous requests are therefore served in rotation; no requester starves.
//  State machine
//   - IDLE: any i_req -> register o_gnt, o_cfg_dwaddr = winner slice, o_cfg_rd_en=1, clear counter.
//     Next state READ. Address and rd_en appear together, 1 cycle after i_req is sampled.
//   - READ: hold o_cfg_rd_en=1 and the address.
//     i_cfg_rd_wr_done=1 -> register o_data=i_cfg_do, o_cfg_rd_en=0, pulse o_ack[gnt], next DRAIN.
//     Ack appears the cycle after done is sampled.
//     Counter reaches TIMEOUT-1 without done -> o_cfg_rd_en=0, o_data=32'hFFFF_FFFF,
//     o_timeout=1 with o_ack pulse, next DRAIN.
//   - DRAIN: wait for i_cfg_rd_wr_done=0, then clear o_gnt and go to IDLE.
//     The core's done may be held over several cycles; this prevents double capture.
//     If done is already low, DRAIN lasts exactly one cycle.
//   - Undefined state -> IDLE with outputs cleared.
//  Timing and counter
//   - Minimum back-to-back spacing: ack, DRAIN (1 cycle), IDLE (1 cycle), new rd_en.
//   - Counter is 16 bits and saturates; it never wraps.
//  Corner cases
//   - o_timeout is low except in the abort ack cycle.
//   - A late done arriving in DRAIN after a timeout is absorbed; no extra ack.
//   - rst_n low mid-access drops o_cfg_rd_en in the same cycle; no ack is issued.
// STRUCTURE
//  - pcie_defines.v gains: CFG_DWADDR_W (10), CFG_RD_ABORT_DATA (32'hFFFF_FFFF).
//  - pcie_defines.v also gains arbiter state encodings CFG_ARB_IDLE/READ/DRAIN.
//  - One sub-module: rr_pick, a combinational round-robin priority encoder.
//    Inputs: req vector, pointer. Outputs: one-hot grant and binary index.
//  - Top holds the FSM, timeout counter, data register and address mux.
// TESTING
//  1 Single read: i_req=01, addr0=10'd4; done 3 cycles after rd_en
//    -> o_cfg_dwaddr=4 with rd_en, o_ack=01 one cycle after done, o_data=i_cfg_do.
//  2 Contention: i_req=11 held for 4 accesses
//    -> grants 01,10,01,10; each ack one-hot and matching the preceding o_gnt.
//  3 Timeout: TIMEOUT=8, done never asserts
//    -> rd_en high exactly 8 cycles; o_ack with o_timeout=1 and o_data=FFFF_FFFF.
//  4 Sticky done: done held 5 cycles
//    -> exactly one ack; next rd_en only after done falls.
//  5 Reset mid-READ: rst_n low while rd_en=1
//    -> all outputs 0 immediately, no ack; after release a fresh request starts at requester 0.
//  6 Early release: requester drops i_req one cycle after grant
//    -> access still completes and ack pulses.

Source files
------------

// File: rtl/cfg_rd_arbiter_pkg.sv
// Shared constants and state encodings for the configuration-space read arbiter.
package cfg_rd_arbiter_pkg;

    localparam int          CFG_DWADDR_W      = 10;
    localparam logic [31:0] CFG_RD_ABORT_DATA = 32'hFFFF_FFFF;
    localparam int          CFG_CNT_W         = 16;

    typedef enum logic [1:0] {
        CFG_ARB_IDLE  = 2'd0,
        CFG_ARB_READ  = 2'd1,
        CFG_ARB_DRAIN = 2'd2
    } cfg_arb_state_e;

    // A single requester still needs a 1-bit pointer/index signal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_rd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
module cfg_rd_arbiter_rr_pick
    import cfg_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx
);

    logic w_found;

    // k is the scan distance from the pointer; p is the absolute position.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int p = 0; p < NUM_REQ; p++) begin
                if (!w_found && i_req[p] && (p == ((int'(i_ptr) + k) % NUM_REQ))) begin
                    w_found  = 1'b1;
                    o_gnt[p] = 1'b1;
                    o_idx    = PTR_W'(p);
                end
            end
        end
    end

endmodule

// File: rtl/cfg_rd_arbiter.sv
// Round-robin arbiter sharing the core's single config-space read port between
// NUM_REQ requesters, with a bounded wait on the core's done strobe.
module cfg_rd_arbiter
    import cfg_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
)
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*CFG_DWADDR_W-1:0]  i_req_dwaddr,
    output logic [NUM_REQ-1:0]               o_gnt,
    output logic [NUM_REQ-1:0]               o_ack,
    output logic [31:0]                      o_data,
    output logic                             o_timeout,
    output logic                             o_busy,
    output logic [CFG_DWADDR_W-1:0]          o_cfg_dwaddr,
    output logic                             o_cfg_rd_en,
    input  logic [31:0]                      i_cfg_do,
    input  logic                             i_cfg_rd_wr_done
);

    localparam int                   PTR_W   = ptr_width(NUM_REQ);
    localparam logic [CFG_CNT_W-1:0] TO_LAST = CFG_CNT_W'(TIMEOUT - 1);
    localparam logic [CFG_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PTR_W-1:0]     PTR_TOP = PTR_W'(NUM_REQ - 1);

    cfg_arb_state_e          r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [CFG_CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_ack;
    logic [31:0]             r_data;
    logic                    r_timeout;
    logic                    r_busy;
    logic [CFG_DWADDR_W-1:0] r_dwaddr;
    logic                    r_rd_en;

    logic [NUM_REQ-1:0]      w_pick_gnt;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_any_req;
    logic [CFG_DWADDR_W-1:0] w_win_addr;
    logic [PTR_W-1:0]        w_next_ptr;

    cfg_rd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    assign w_any_req  = |i_req;
    assign w_next_ptr = (w_pick_idx == PTR_TOP) ? '0 : w_pick_idx + PTR_W'(1);

    // One-hot grant selects the address slice as a plain AND-OR mux.
    always_comb begin
        w_win_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_win_addr = w_win_addr | i_req_dwaddr[k*CFG_DWADDR_W +: CFG_DWADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CFG_ARB_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_dwaddr  <= '0;
            r_rd_en   <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                CFG_ARB_IDLE: begin
                    if (w_any_req) begin
                        r_gnt    <= w_pick_gnt;
                        r_dwaddr <= w_win_addr;
                        r_rd_en  <= 1'b1;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_ptr    <= w_next_ptr;
                        r_state  <= CFG_ARB_READ;
                    end
                end
                CFG_ARB_READ: begin
                    // A done in the same cycle as the last allowed count still wins.
                    if (i_cfg_rd_wr_done) begin
                        r_data  <= i_cfg_do;
                        r_rd_en <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= CFG_ARB_DRAIN;
                    end else if (r_cnt == TO_LAST) begin
                        r_data    <= CFG_RD_ABORT_DATA;
                        r_rd_en   <= 1'b0;
                        r_ack     <= r_gnt;
                        r_timeout <= 1'b1;
                        r_state   <= CFG_ARB_DRAIN;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CFG_CNT_W'(1);
                    end
                end
                CFG_ARB_DRAIN: begin
                    // Hold off re-arbitration until the core lets go of done.
                    if (!i_cfg_rd_wr_done) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= CFG_ARB_IDLE;
                    end
                end
                default: begin
                    r_gnt     <= '0;
                    r_ack     <= '0;
                    r_data    <= '0;
                    r_timeout <= 1'b0;
                    r_busy    <= 1'b0;
                    r_dwaddr  <= '0;
                    r_rd_en   <= 1'b0;
                    r_state   <= CFG_ARB_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_ack        = r_ack;
    assign o_data       = r_data;
    assign o_timeout    = r_timeout;
    assign o_busy       = r_busy;
    assign o_cfg_dwaddr = r_dwaddr;
    assign o_cfg_rd_en  = r_rd_en;

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ack));
    a_timeout_qualified: assert property (@(posedge clk) disable iff (!rst_n) r_timeout |-> (|r_ack));
`endif

endmodule

// File: tb/tb_cfg_rd_arbiter.sv
// Directed bench for cfg_rd_arbiter: single read, contention, timeout, sticky
// done, early release and reset in the middle of an access.
module tb_cfg_rd_arbiter;

  localparam int TB_NUM_REQ = 2;
  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  i_req;
  logic [19:0] i_req_dwaddr;
  logic [1:0]  o_gnt;
  logic [1:0]  o_ack;
  logic [31:0] o_data;
  logic        o_timeout;
  logic        o_busy;
  logic [9:0]  o_cfg_dwaddr;
  logic        o_cfg_rd_en;
  logic [31:0] i_cfg_do;
  logic        i_cfg_rd_wr_done;

  int n_total = 0;
  int n_bad   = 0;

  cfg_rd_arbiter #(
    .NUM_REQ (TB_NUM_REQ),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req            (i_req),
    .i_req_dwaddr     (i_req_dwaddr),
    .o_gnt            (o_gnt),
    .o_ack            (o_ack),
    .o_data           (o_data),
    .o_timeout        (o_timeout),
    .o_busy           (o_busy),
    .o_cfg_dwaddr     (o_cfg_dwaddr),
    .o_cfg_rd_en      (o_cfg_rd_en),
    .i_cfg_do         (i_cfg_do),
    .i_cfg_rd_wr_done (i_cfg_rd_wr_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One complete access from request to return to IDLE.
  // dly: cycles rd_en is seen high before done is driven; hold: cycles done stays high
  // (after a timeout, hold is the length of a late done in DRAIN).
  task automatic run_access(input string tag, input logic [1:0] exp_gnt, input logic [9:0] exp_addr,
                            input int dly, input int hold, input bit mute, input bit keep_req,
                            input bit early_drop, input logic [31:0] rd_data);
    int waits;
    int hi;
    logic [31:0] exp_data;
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!o_cfg_rd_en && waits < 20);
    chk({tag, "_lat"}, 32'(waits), 32'd1);
    chk({tag, "_gnt"}, 32'(o_gnt), 32'(exp_gnt));
    chk({tag, "_addr"}, 32'(o_cfg_dwaddr), 32'(exp_addr));
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_ack0"}, 32'(o_ack), 32'd0);
    if (!mute) begin
      for (int i = 1; i <= dly; i++) begin
        tick();
        if (early_drop && i == 1) i_req = i_req & ~exp_gnt;
        chk({tag, "_rden_hold"}, 32'(o_cfg_rd_en), 32'd1);
        chk({tag, "_ack_early"}, 32'(o_ack), 32'd0);
      end
      i_cfg_rd_wr_done = 1'b1;
      i_cfg_do = rd_data;
      tick();
      exp_data = rd_data;
      chk({tag, "_ack"}, 32'(o_ack), 32'(exp_gnt));
      chk({tag, "_data"}, o_data, exp_data);
      chk({tag, "_to"}, 32'(o_timeout), 32'd0);
      chk({tag, "_rden_off"}, 32'(o_cfg_rd_en), 32'd0);
      chk({tag, "_gnt_ack"}, 32'(o_gnt), 32'(exp_gnt));
      if (!keep_req) i_req = i_req & ~exp_gnt;
      i_cfg_do = ~rd_data;
      for (int i = 1; i < hold; i++) begin
        tick();
        chk({tag, "_drain_ack"}, 32'(o_ack), 32'd0);
        chk({tag, "_drain_rden"}, 32'(o_cfg_rd_en), 32'd0);
        chk({tag, "_drain_gnt"}, 32'(o_gnt), 32'(exp_gnt));
      end
      i_cfg_rd_wr_done = 1'b0;
    end else begin
      hi = 1;
      while (o_cfg_rd_en && hi < 40) begin
        tick();
        if (o_cfg_rd_en) hi++;
      end
      exp_data = 32'hFFFF_FFFF;
      chk({tag, "_rden_cycles"}, 32'(hi), 32'(TB_TIMEOUT));
      chk({tag, "_ack"}, 32'(o_ack), 32'(exp_gnt));
      chk({tag, "_to"}, 32'(o_timeout), 32'd1);
      chk({tag, "_data"}, o_data, exp_data);
      if (!keep_req) i_req = i_req & ~exp_gnt;
      if (hold > 0) i_cfg_rd_wr_done = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_late_ack"}, 32'(o_ack), 32'd0);
        chk({tag, "_late_to"}, 32'(o_timeout), 32'd0);
        chk({tag, "_late_gnt"}, 32'(o_gnt), 32'(exp_gnt));
      end
      i_cfg_rd_wr_done = 1'b0;
    end
    tick();
    chk({tag, "_end_gnt"}, 32'(o_gnt), 32'd0);
    chk({tag, "_end_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_end_ack"}, 32'(o_ack), 32'd0);
    chk({tag, "_end_to"}, 32'(o_timeout), 32'd0);
    chk({tag, "_end_data"}, o_data, exp_data);
  endtask

  initial begin
    rst_n            = 1'b0;
    i_req            = '0;
    i_req_dwaddr     = '0;
    i_cfg_do         = '0;
    i_cfg_rd_wr_done = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_to", 32'(o_timeout), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_addr", 32'(o_cfg_dwaddr), 32'd0);
    chk("rst_rden", 32'(o_cfg_rd_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // single read from requester 0
    i_req = 2'b01;
    i_req_dwaddr[9:0] = 10'd4;
    run_access("single", 2'b01, 10'd4, 3, 1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // contention: both held for four accesses, pointer restarted at 0
    reset_pulse();
    i_req = 2'b11;
    i_req_dwaddr[9:0]   = 10'h011;
    i_req_dwaddr[19:10] = 10'h022;
    run_access("cont1", 2'b01, 10'h011, 2, 1, 1'b0, 1'b1, 1'b0, 32'h1111_0001);
    run_access("cont2", 2'b10, 10'h022, 1, 1, 1'b0, 1'b1, 1'b0, 32'h2222_0002);
    run_access("cont3", 2'b01, 10'h011, 0, 1, 1'b0, 1'b1, 1'b0, 32'h1111_0003);
    run_access("cont4", 2'b10, 10'h022, 4, 1, 1'b0, 1'b1, 1'b0, 32'h2222_0004);
    i_req = 2'b00;

    // sticky done with the request left high through DRAIN
    i_req = 2'b10;
    i_req_dwaddr[19:10] = 10'h3FF;
    run_access("sticky", 2'b10, 10'h3FF, 1, 5, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
    i_req = 2'b00;

    // timeout with a late done absorbed in DRAIN
    i_req = 2'b01;
    i_req_dwaddr[9:0] = 10'h000;
    run_access("tmo", 2'b01, 10'h000, 0, 2, 1'b1, 1'b0, 1'b0, 32'h0);

    // early release of the request after grant
    i_req = 2'b10;
    i_req_dwaddr[19:10] = 10'h155;
    run_access("early", 2'b10, 10'h155, 3, 1, 1'b0, 1'b0, 1'b1, 32'h5A5A_A5A5);
    chk("early_req_dropped", 32'(i_req), 32'd0);

    // reset in the middle of READ, after the pointer has moved to 1
    i_req = 2'b01;
    i_req_dwaddr[9:0] = 10'h007;
    tick();
    chk("mrst_rden_up", 32'(o_cfg_rd_en), 32'd1);
    tick();
    chk("mrst_rden_read", 32'(o_cfg_rd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rden", 32'(o_cfg_rd_en), 32'd0);
    chk("mrst_gnt", 32'(o_gnt), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_addr", 32'(o_cfg_dwaddr), 32'd0);
    chk("mrst_data", o_data, 32'd0);
    chk("mrst_ack", 32'(o_ack), 32'd0);
    tick();
    tick();
    chk("mrst_ack_hold", 32'(o_ack), 32'd0);
    i_req = 2'b11;
    i_req_dwaddr[19:10] = 10'h009;
    rst_n = 1'b1;
    run_access("post_rst", 2'b01, 10'h007, 1, 1, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    i_req = 2'b00;
    tick();
    chk("idle_rden", 32'(o_cfg_rd_en), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
